// File: rtl/lcd_frame_sequencer_if.sv
// lcd_frame_sequencer_if: AHB-Lite write-master bus between the frame sequencer and the matrix.
interface lcd_frame_sequencer_if #(
   parameter int unsigned W_ADDR = 32,
   parameter int unsigned W_DATA = 32
) ();
   logic [1:0]        HTRANS;
   logic [2:0]        HBURST;
   logic [2:0]        HSIZE;
   logic [3:0]        HPROT;
   logic [W_ADDR-1:0] HADDR;
   logic              HWRITE;
   logic [W_DATA-1:0] HWDATA;
   logic              HREADY;
   logic [1:0]        HRESP;

   modport master (
      output HTRANS, HBURST, HSIZE, HPROT, HADDR, HWRITE, HWDATA,
      input  HREADY, HRESP
   );

   modport slave (
      input  HTRANS, HBURST, HSIZE, HPROT, HADDR, HWRITE, HWDATA,
      output HREADY, HRESP
   );
endinterface

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: AHB-Lite master that programs lcd_drive_if and sequences a burst of frames,
// stepping brightness per frame and detecting end-of-frame by counting the driver's out_valid.
// Build option: define LCD_SEQ_BR_WRAP_EN to wrap the brightness step modulo 256 (default saturates).
module lcd_frame_sequencer #(
   parameter int unsigned       W_ADDR     = 32,
   parameter int unsigned       W_DATA     = 32,
   parameter logic [W_ADDR-1:0] LCD_BASE   = '0,
   parameter int unsigned       WIDTH      = 768,
   parameter int unsigned       HEIGHT     = 512,
   parameter int unsigned       DATA_COUNT = WIDTH * HEIGHT / 2,
   parameter int unsigned       W_FRM      = 8
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             seq_start,
   input  logic             seq_abort,
   input  logic [W_FRM-1:0] cfg_n_frames,
   input  logic             cfg_br_mode,
   input  logic [7:0]       cfg_br_init,
   input  logic [7:0]       cfg_br_step,
   input  logic             lcd_valid,
   lcd_frame_sequencer_if.master m,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [W_FRM-1:0] frame_idx
);
   localparam int unsigned       W_VCNT       = 25;
   localparam logic [1:0]        HTRANS_IDLE  = 2'b00;
   localparam logic [1:0]        HTRANS_NSEQ  = 2'b10;
   localparam logic [1:0]        RESP_ERROR   = 2'b01;
   localparam logic [W_VCNT-1:0] FRAME_VALIDS = W_VCNT'(DATA_COUNT + 1);

   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_WAIT_FIRST, ST_WAIT_END} state_t;
   typedef enum logic [3:0] {WR_WIDTH, WR_HEIGHT, WR_DCNT, WR_MODE, WR_BR_CFG,
                             WR_START, WR_STOP, WR_BR_NEXT, WR_ABORT} wr_t;

   state_t            state_q, state_d;
   wr_t               wr_q, wr_d;
   logic [W_FRM-1:0]  n_frames_q, n_frames_d;
   logic              mode_q, mode_d;
   logic [7:0]        br_q, br_d;
   logic [7:0]        step_q, step_d;
   logic [W_VCNT-1:0] vcnt_q, vcnt_d;
   logic [W_FRM-1:0]  frame_q, frame_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              abort_q, abort_d;
   logic [1:0]        htrans_q, htrans_d;
   logic [W_ADDR-1:0] haddr_q, haddr_d;
   logic              hwrite_q, hwrite_d;
   logic [W_DATA-1:0] hwdata_q, hwdata_d;

   logic [8:0]        br_sum;
   logic [7:0]        br_next;
   logic [W_FRM-1:0]  frame_inc;
   logic              abort_now;
   logic              launch;
   wr_t               launch_wr;
   logic [7:0]        launch_off;
   logic [W_DATA-1:0] launch_data;

   // Per-frame brightness step: 9-bit sum, then saturate or wrap.
   assign br_sum = {1'b0, br_q} + {1'b0, step_q};
`ifdef LCD_SEQ_BR_WRAP_EN
   assign br_next = br_sum[7:0];
`else
   assign br_next = br_sum[8] ? 8'hFF : br_sum[7:0];
`endif

   assign frame_inc = frame_q + W_FRM'(1);
   assign abort_now = seq_abort | abort_q;

   // State register and all registered outputs.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         wr_q       <= WR_WIDTH;
         n_frames_q <= '0;
         mode_q     <= 1'b0;
         br_q       <= '0;
         step_q     <= '0;
         vcnt_q     <= '0;
         frame_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         abort_q    <= 1'b0;
         htrans_q   <= HTRANS_IDLE;
         haddr_q    <= '0;
         hwrite_q   <= 1'b0;
         hwdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         n_frames_q <= n_frames_d;
         mode_q     <= mode_d;
         br_q       <= br_d;
         step_q     <= step_d;
         vcnt_q     <= vcnt_d;
         frame_q    <= frame_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         abort_q    <= abort_d;
         htrans_q   <= htrans_d;
         haddr_q    <= haddr_d;
         hwrite_q   <= hwrite_d;
         hwdata_q   <= hwdata_d;
      end
   end

   // Sequencer next-state: frame flow, single-outstanding write engine, abort handling.
   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      n_frames_d  = n_frames_q;
      mode_d      = mode_q;
      br_d        = br_q;
      step_d      = step_q;
      vcnt_d      = vcnt_q + W_VCNT'(lcd_valid);
      frame_d     = frame_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      abort_d     = abort_q | (seq_abort & (state_q != ST_IDLE));
      htrans_d    = htrans_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hwdata_d    = hwdata_q;
      launch      = 1'b0;
      launch_wr   = wr_q;
      launch_off  = 8'h00;
      launch_data = '0;

      case (state_q)
         ST_IDLE: begin
            vcnt_d  = '0;
            abort_d = 1'b0;
            if (seq_start && !seq_abort) begin
               n_frames_d = cfg_n_frames;
               mode_d     = cfg_br_mode;
               br_d       = cfg_br_init;
               step_d     = cfg_br_step;
               frame_d    = '0;
               err_d      = 1'b0;
               if (cfg_n_frames == '0) begin
                  done_d = 1'b1;
               end else begin
                  busy_d    = 1'b1;
                  launch    = 1'b1;
                  launch_wr = WR_WIDTH;
               end
            end
         end
         ST_ADDR: begin
            if (m.HREADY) begin
               state_d  = ST_DATA;
               htrans_d = HTRANS_IDLE;
               hwrite_d = 1'b0;
            end
         end
         ST_DATA: begin
            if (m.HRESP == RESP_ERROR) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               abort_d = 1'b0;
               state_d = ST_IDLE;
            end else if (m.HREADY) begin
               if (wr_q == WR_ABORT) begin
                  busy_d  = 1'b0;
                  abort_d = 1'b0;
                  state_d = ST_IDLE;
               end else if (abort_now) begin
                  launch    = 1'b1;
                  launch_wr = WR_ABORT;
               end else begin
                  case (wr_q)
                     WR_WIDTH:  begin launch = 1'b1; launch_wr = WR_HEIGHT; end
                     WR_HEIGHT: begin launch = 1'b1; launch_wr = WR_DCNT;   end
                     WR_DCNT:   begin launch = 1'b1; launch_wr = WR_MODE;   end
                     WR_MODE:   begin launch = 1'b1; launch_wr = WR_BR_CFG; end
                     WR_BR_CFG, WR_BR_NEXT: begin
                        launch    = 1'b1;
                        launch_wr = WR_START;
                        vcnt_d    = '0;
                     end
                     WR_START:  state_d = ST_WAIT_FIRST;
                     WR_STOP:   state_d = ST_WAIT_END;
                     default:   state_d = ST_IDLE;
                  endcase
               end
            end
         end
         ST_WAIT_FIRST: begin
            if (abort_now) begin
               launch    = 1'b1;
               launch_wr = WR_ABORT;
            end else if (lcd_valid || (vcnt_q != '0)) begin
               launch    = 1'b1;
               launch_wr = WR_STOP;
            end
         end
         ST_WAIT_END: begin
            if (abort_now) begin
               launch    = 1'b1;
               launch_wr = WR_ABORT;
            end else if (vcnt_q >= FRAME_VALIDS) begin
               frame_d = frame_inc;
               if (frame_inc == n_frames_q) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  br_d      = br_next;
                  launch    = 1'b1;
                  launch_wr = WR_BR_NEXT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case (launch_wr)
         WR_WIDTH:   begin launch_off = 8'h00; launch_data = W_DATA'(WIDTH);      end
         WR_HEIGHT:  begin launch_off = 8'h04; launch_data = W_DATA'(HEIGHT);     end
         WR_DCNT:    begin launch_off = 8'h1C; launch_data = W_DATA'(DATA_COUNT); end
         WR_MODE:    begin launch_off = 8'h24; launch_data = W_DATA'(mode_d);     end
         WR_BR_CFG,
         WR_BR_NEXT: begin launch_off = 8'h28; launch_data = W_DATA'(br_d);       end
         WR_START:   begin launch_off = 8'h20; launch_data = W_DATA'(1);          end
         default:    begin launch_off = 8'h20; launch_data = '0;                  end
      endcase

      if (launch) begin
         state_d  = ST_ADDR;
         wr_d     = launch_wr;
         htrans_d = HTRANS_NSEQ;
         hwrite_d = 1'b1;
         haddr_d  = LCD_BASE + W_ADDR'(launch_off);
         hwdata_d = launch_data;
      end
   end

   assign m.HTRANS = htrans_q;
   assign m.HBURST = 3'b000;
   assign m.HSIZE  = 3'b010;
   assign m.HPROT  = 4'b0001;
   assign m.HADDR  = haddr_q;
   assign m.HWRITE = hwrite_q;
   assign m.HWDATA = hwdata_q;

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign frame_idx = frame_q;
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb_lcd_frame_sequencer: AHB slave model with wait states / ERROR injection plus a tiny LCD driver model.
module tb_lcd_frame_sequencer;
   localparam logic [1:0] NONSEQ = 2'b10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       seq_start = 1'b0;
   logic       seq_abort = 1'b0;
   logic [7:0] cfg_n_frames = '0;
   logic       cfg_br_mode = 1'b0;
   logic [7:0] cfg_br_init = '0;
   logic [7:0] cfg_br_step = '0;
   logic       lcd_valid;
   logic       busy, done, err;
   logic [7:0] frame_idx;

   always #5 clk = ~clk;

   lcd_frame_sequencer_if bus ();

   lcd_frame_sequencer #(
      .LCD_BASE(32'h0), .WIDTH(8), .HEIGHT(4), .DATA_COUNT(16)
   ) dut (
      .HCLK(clk), .HRESETn(rst_n), .seq_start(seq_start), .seq_abort(seq_abort),
      .cfg_n_frames(cfg_n_frames), .cfg_br_mode(cfg_br_mode), .cfg_br_init(cfg_br_init),
      .cfg_br_step(cfg_br_step), .lcd_valid(lcd_valid), .m(bus),
      .busy(busy), .done(done), .err(err), .frame_idx(frame_idx)
   );

   // Slave / driver model state
   int          ws = 0;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = '0;
   logic        phase = 1'b0;
   int          wcnt = 0;
   logic [31:0] cap_addr = '0, hold_addr = '0, hold_data = '0;
   int          dly = 0, rem = 0, vseen = 0, starts = 0;
   int          log_n = 0, accepted = 0, stab_err = 0;
   logic [31:0] log_addr [0:255];
   logic [31:0] log_data [0:255];

   assign bus.HREADY = (wcnt == ws) || (!phase && bus.HTRANS != NONSEQ);
   assign bus.HRESP  = (phase && wcnt == ws && err_en && cap_addr == err_addr) ? 2'b01 : 2'b00;
   assign lcd_valid  = (dly == 0) && (rem != 0);

   // AHB slave with wait states, write log, protocol stability checks, LCD valid generator
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 1'b0; wcnt <= 0; dly <= 0; rem <= 0;
      end else begin
         if (dly != 0) dly <= dly - 1;
         else if (rem != 0) begin rem <= rem - 1; vseen <= vseen + 1; end
         if (!phase) begin
            if (bus.HTRANS == NONSEQ) begin
               if (wcnt == 0) hold_addr <= bus.HADDR;
               else if (bus.HADDR !== hold_addr) stab_err <= stab_err + 1;
               if (wcnt == ws) begin
                  cap_addr <= bus.HADDR; phase <= 1'b1; wcnt <= 0; accepted <= accepted + 1;
                  if (bus.HWRITE !== 1'b1) stab_err <= stab_err + 1;
               end else wcnt <= wcnt + 1;
            end else if (wcnt != 0) stab_err <= stab_err + 1;
         end else begin
            if (bus.HTRANS != 2'b00) stab_err <= stab_err + 1;
            if (wcnt == 0) hold_data <= bus.HWDATA;
            else if (bus.HWDATA !== hold_data) stab_err <= stab_err + 1;
            if (wcnt == ws) begin
               phase <= 1'b0; wcnt <= 0;
               if (!(err_en && cap_addr == err_addr)) begin
                  log_addr[log_n] <= cap_addr; log_data[log_n] <= bus.HWDATA; log_n <= log_n + 1;
                  if (cap_addr == 32'h20 && bus.HWDATA == 32'h1) begin
                     dly <= 3; rem <= 17; vseen <= 0; starts <= starts + 1;
                  end
               end
            end else wcnt <= wcnt + 1;
         end
      end
   end

   // Output monitor
   int done_cnt = 0, busy_cnt = 0, vseen_at_done = -1;
   always @(negedge clk) begin
      if (done === 1'b1) begin done_cnt++; vseen_at_done = vseen; end
      if (busy === 1'b1) busy_cnt++;
   end

   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input logic [7:0] n, input logic [7:0] init,
                              input logic [7:0] step, input logic mode);
      @(negedge clk);
      cfg_n_frames = n; cfg_br_init = init; cfg_br_step = step; cfg_br_mode = mode;
      seq_start = 1'b1;
      @(negedge clk);
      seq_start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (busy === 1'b1 && t < 3000) begin @(negedge clk); t++; end
      check(name, 32'(t < 3000), 32'd1);
   endtask

   typedef struct {
      logic [7:0] n, init, step;
      logic       mode;
      int         ws, exp_wr;
      logic [7:0] br0, br1, br2;
   } vec_t;

   vec_t        vecs [5];
   logic [7:0]  exp_br [3];
   logic [7:0]  got_br [3];
   logic [31:0] t1_addr [7];
   logic [31:0] t1_data [7];
   int lm, dm, bm, sm, am, stm, nb, t;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'd1, 8'h10, 8'h00, 1'b1, 0, 7,  8'h10, 8'h00, 8'h00};
`ifdef LCD_SEQ_BR_WRAP_EN
      vecs[1] = '{8'd3, 8'h80, 8'h60, 1'b0, 0, 13, 8'h80, 8'hE0, 8'h40};
`else
      vecs[1] = '{8'd3, 8'h80, 8'h60, 1'b0, 0, 13, 8'h80, 8'hE0, 8'hFF};
`endif
      vecs[2] = '{8'd2, 8'h20, 8'h10, 1'b1, 3, 10, 8'h20, 8'h30, 8'h00};
      vecs[3] = '{8'd0, 8'h55, 8'h01, 1'b1, 0, 0,  8'h00, 8'h00, 8'h00};
      vecs[4] = '{8'd2, 8'hFE, 8'h01, 1'b0, 1, 10, 8'hFE, 8'hFF, 8'h00};
      t1_addr = '{32'h00, 32'h04, 32'h1C, 32'h24, 32'h28, 32'h20, 32'h20};
      t1_data = '{32'd8, 32'd4, 32'd16, 32'd1, 32'h10, 32'd1, 32'd0};

      // Reset state
      cyc(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_frame_idx", 32'(frame_idx), 32'd0);
      check("rst_htrans", 32'(bus.HTRANS), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // Table-driven sequences
      for (int i = 0; i < 5; i++) begin
         ws = vecs[i].ws;
         lm = log_n; dm = done_cnt; bm = busy_cnt; sm = stab_err; am = accepted;
         pulse_start(vecs[i].n, vecs[i].init, vecs[i].step, vecs[i].mode);
         wait_idle($sformatf("v%0d_timeout", i));
         cyc(25);
         check($sformatf("v%0d_writes", i), 32'(log_n - lm), 32'(vecs[i].exp_wr));
         check($sformatf("v%0d_nonseq", i), 32'(accepted - am), 32'(vecs[i].exp_wr));
         exp_br[0] = vecs[i].br0; exp_br[1] = vecs[i].br1; exp_br[2] = vecs[i].br2;
         nb = 0;
         for (int j = lm; j < log_n; j++) begin
            if (log_addr[j] == 32'h28) begin
               if (nb < 3) got_br[nb] = log_data[j][7:0];
               nb++;
            end
         end
         check($sformatf("v%0d_br_count", i), 32'(nb), 32'(vecs[i].n));
         for (int k = 0; k < nb && k < 3; k++)
            check($sformatf("v%0d_br%0d", i, k), 32'(got_br[k]), 32'(exp_br[k]));
         check($sformatf("v%0d_frame_idx", i), 32'(frame_idx), 32'(vecs[i].n));
         check($sformatf("v%0d_done_pulses", i), 32'(done_cnt - dm), 32'd1);
         check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
         check($sformatf("v%0d_err", i), 32'(err), 32'd0);
         check($sformatf("v%0d_stability", i), 32'(stab_err - sm), 32'd0);
         if (vecs[i].n == 8'd0)
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt - bm), 32'd0);
      end

      // Single frame: exact write stream and done after 17 valids
      ws = 0;
      lm = log_n;
      pulse_start(8'd1, 8'h10, 8'h00, 1'b1);
      wait_idle("t1_timeout");
      cyc(5);
      check("t1_writes", 32'(log_n - lm), 32'd7);
      for (int k = 0; k < 7; k++) begin
         check($sformatf("t1_addr%0d", k), log_addr[lm + k], t1_addr[k]);
         check($sformatf("t1_data%0d", k), log_data[lm + k], t1_data[k]);
      end
      check("t1_valids_at_done", 32'(vseen_at_done), 32'd17);

      // ERROR on HEIGHT write
      err_en = 1'b1; err_addr = 32'h04;
      lm = log_n; dm = done_cnt; am = accepted;
      pulse_start(8'd2, 8'h10, 8'h00, 1'b0);
      t = 0;
      while (bus.HRESP !== 2'b01 && t < 100) begin @(negedge clk); t++; end
      check("t4_error_seen", 32'(t < 100), 32'd1);
      @(posedge clk); #1;
      check("t4_busy_next", 32'(busy), 32'd0);
      check("t4_err_set", 32'(err), 32'd1);
      cyc(20);
      err_en = 1'b0;
      check("t4_nonseq", 32'(accepted - am), 32'd2);
      check("t4_logged", 32'(log_n - lm), 32'd1);
      check("t4_no_done", 32'(done_cnt - dm), 32'd0);
      check("t4_err_sticky", 32'(err), 32'd1);
      pulse_start(8'd0, 8'h00, 8'h00, 1'b0);
      cyc(1);
      check("t4_err_cleared", 32'(err), 32'd0);

      // Abort at valid count 5 of frame 2
      lm = log_n; dm = done_cnt; stm = starts;
      pulse_start(8'd3, 8'h10, 8'h10, 1'b0);
      t = 0;
      while (!(starts - stm == 2 && vseen == 5) && t < 2000) begin @(negedge clk); t++; end
      check("t5_reach_frame2", 32'(t < 2000), 32'd1);
      lm = log_n;
      seq_abort = 1'b1;
      @(negedge clk);
      seq_abort = 1'b0;
      wait_idle("t5_timeout");
      cyc(25);
      check("t5_abort_writes", 32'(log_n - lm), 32'd1);
      check("t5_abort_addr", log_addr[lm], 32'h20);
      check("t5_abort_data", log_data[lm], 32'h0);
      check("t5_no_done", 32'(done_cnt - dm), 32'd0);
      check("t5_frame_idx", 32'(frame_idx), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);

      // Async reset during address phase, then during data phase
      ws = 3;
      pulse_start(8'd1, 8'h10, 8'h00, 1'b0);
      t = 0;
      while (!(!phase && wcnt >= 1) && t < 100) begin @(negedge clk); t++; end
      check("t6_addr_wait", 32'(bus.HTRANS), 32'(NONSEQ));
      #2 rst_n = 1'b0;
      #1;
      check("t6_addr_rst_htrans", 32'(bus.HTRANS), 32'd0);
      check("t6_addr_rst_busy", 32'(busy), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      pulse_start(8'd1, 8'h10, 8'h00, 1'b0);
      t = 0;
      while (!phase && t < 100) begin @(negedge clk); t++; end
      check("t6_data_phase", 32'(phase), 32'd1);
      check("t6_busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_data_rst_busy", 32'(busy), 32'd0);
      check("t6_data_rst_htrans", 32'(bus.HTRANS), 32'd0);
      check("t6_data_rst_frame", 32'(frame_idx), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      ws = 0;
      cyc(5);
      check("t6_idle_after", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
